// File: rtl/top_level_pkg.sv
// Shared types and constants for the pattern-search program engine.
package top_level_pkg;

    typedef enum logic [2:0] {
        LOAD_PAT,
        SCAN,
        WR_CTB,
        WR_CTO,
        WR_CTS,
        WR_CYC,
        DONE
    } state_t;

    localparam logic [7:0] ADDR_PAT = 8'd32;
    localparam logic [7:0] ADDR_CTB = 8'd33;
    localparam logic [7:0] ADDR_CTO = 8'd34;
    localparam logic [7:0] ADDR_CTS = 8'd35;
    localparam logic [7:0] ADDR_CYC = 8'd36;
    localparam int         MSG_BYTES = 32;

    // Counts how many of the four 5-bit windows starting at bit lo of w equal p.
    function automatic logic [2:0] count4(input logic [15:0] w, input int lo, input logic [4:0] p);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (w[(lo + k) +: 5] == p) cnt = cnt + 3'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// 256x8 data memory: combinational read, synchronous write, no reset.
module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] core [0:255];

    assign rdata = core[addr];

    always_ff @(posedge clk) begin
        if (we) core[addr] <= wdata;
    end

endmodule

// File: rtl/top_level.sv
// Program engine, progID=3 runs a 5-bit pattern search over 32 message bytes.
// Optional TOP_LEVEL_CYCLE_COUNT_EN stores the run's cycle count into core[36].
module top_level
    import top_level_pkg::*;
#(
    parameter int progID = 3
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    state_t     state, next_state;
    logic [4:0] idx;
    logic [4:0] pat;
    logic [7:0] prev;
    logic [7:0] ctb, cto, cts;

    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0] in_cnt, cross_cnt;

    data_mem dm1 (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Crossing windows straddle the previous byte's low nibble and the current byte's high bits.
    assign in_cnt    = count4({8'h00, mem_rdata}, 0, pat);
    assign cross_cnt = count4({prev, mem_rdata}, 4, pat);

`ifdef TOP_LEVEL_CYCLE_COUNT_EN
    logic [7:0] cyc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cyc <= 8'd0;
        else       cyc <= cyc + 8'd1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD_PAT;
            idx   <= 5'd0;
            pat   <= 5'd0;
            prev  <= 8'd0;
            ctb   <= 8'd0;
            cto   <= 8'd0;
            cts   <= 8'd0;
        end else begin
            state <= next_state;
            case (state)
                LOAD_PAT: pat <= mem_rdata[4:0];
                SCAN: begin
                    ctb  <= ctb + 8'(in_cnt);
                    cto  <= cto + {7'd0, (in_cnt != 3'd0)};
                    cts  <= cts + 8'(in_cnt) + ((idx != 5'd0) ? 8'(cross_cnt) : 8'd0);
                    prev <= mem_rdata;
                    idx  <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        mem_addr   = ADDR_PAT;
        mem_we     = 1'b0;
        mem_wdata  = 8'd0;
        done       = 1'b0;
        case (state)
            LOAD_PAT: next_state = (progID == 3) ? SCAN : DONE;
            SCAN: begin
                mem_addr = {3'b000, idx};
                if (idx == 5'(MSG_BYTES - 1)) next_state = WR_CTB;
            end
            WR_CTB: begin
                mem_addr   = ADDR_CTB;
                mem_we     = 1'b1;
                mem_wdata  = ctb;
                next_state = WR_CTO;
            end
            WR_CTO: begin
                mem_addr   = ADDR_CTO;
                mem_we     = 1'b1;
                mem_wdata  = cto;
                next_state = WR_CTS;
            end
            WR_CTS: begin
                mem_addr  = ADDR_CTS;
                mem_we    = 1'b1;
                mem_wdata = cts;
`ifdef TOP_LEVEL_CYCLE_COUNT_EN
                next_state = WR_CYC;
`else
                next_state = DONE;
`endif
            end
`ifdef TOP_LEVEL_CYCLE_COUNT_EN
            WR_CYC: begin
                mem_addr   = ADDR_CYC;
                mem_we     = 1'b1;
                mem_wdata  = cyc;
                next_state = DONE;
            end
`endif
            DONE:    done = 1'b1;
            default: next_state = DONE;
        endcase
    end

endmodule

// File: tb/tb_top_level.sv
// Directed and random checks of the pattern-search engine, including reset aborts and a no-op program.
module tb_top_level;

`ifdef TOP_LEVEL_CYCLE_COUNT_EN
    localparam int EXP_LAT = 37;
`else
    localparam int EXP_LAT = 36;
`endif
    localparam int MAX_EDGES = 200;

    typedef struct {
        logic [7:0] fill;
        logic [7:0] pat;
        int         ctb;
        int         cto;
        int         cts;
    } vec_t;

    logic clk;
    logic reset;
    logic done;
    logic reset_np;
    logic done_np;

    int compared;
    int mismatched;

    logic [7:0] msg_buf [0:31];
    logic [7:0] pat_buf;
    int exp_ctb, exp_cto, exp_cts;
    int edges;

    vec_t vecs [6];

    top_level #(.progID(3)) dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    top_level #(.progID(0)) dut_np (
        .clk   (clk),
        .reset (reset_np),
        .done  (done_np)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Bench model: windows taken directly from the 256-bit string, core[0] as MSB byte.
    task automatic compute_model();
        logic [255:0] s;
        int base, in_cnt;
        for (int i = 0; i < 32; i++) s[255 - 8*i -: 8] = msg_buf[i];
        exp_ctb = 0; exp_cto = 0; exp_cts = 0;
        for (int i = 0; i < 32; i++) begin
            base   = 248 - 8*i;
            in_cnt = 0;
            for (int k = 0; k < 4; k++)
                if (s[base + k +: 5] == pat_buf[4:0]) in_cnt++;
            exp_ctb += in_cnt;
            exp_cto += (in_cnt > 0) ? 1 : 0;
            exp_cts += in_cnt;
            if (i > 0)
                for (int k = 4; k < 8; k++)
                    if (s[base + k +: 5] == pat_buf[4:0]) exp_cts++;
        end
    endtask

    task automatic load_dut();
        for (int i = 0; i < 32; i++) dut.dm1.core[i] = msg_buf[i];
        dut.dm1.core[32] = pat_buf;
        dut.dm1.core[33] = 8'hEE;
        dut.dm1.core[34] = 8'hEE;
        dut.dm1.core[35] = 8'hEE;
        dut.dm1.core[36] = 8'hA5;
    endtask

    task automatic apply_stimulus(input string name);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output({name, "_reset_done"}, int'(done), 0);
        reset = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < MAX_EDGES) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_results(input string name, input int lat);
        check_output({name, "_latency"}, lat, EXP_LAT);
        check_output({name, "_ctb"}, int'(dut.dm1.core[33]), exp_ctb);
        check_output({name, "_cto"}, int'(dut.dm1.core[34]), exp_cto);
        check_output({name, "_cts"}, int'(dut.dm1.core[35]), exp_cts);
`ifdef TOP_LEVEL_CYCLE_COUNT_EN
        check_output({name, "_cyc"}, int'(dut.dm1.core[36]), 36);
`else
        check_output({name, "_core36"}, int'(dut.dm1.core[36]), 8'hA5);
`endif
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        reset_np   = 1'b1;

        vecs[0] = '{8'h00, 8'h00, 128, 32, 252};
        vecs[1] = '{8'h55, 8'h15,  64, 32, 126};
        vecs[2] = '{8'hFF, 8'hFF, 128, 32, 252};
        vecs[3] = '{8'h00, 8'h01,   0,  0,   0};
        vecs[4] = '{8'hAA, 8'h0A,  64, 32, 126};
        vecs[5] = '{8'h00, 8'h10,   0,  0,   0};

        for (int v = 0; v < 6; v++) begin
            string name;
            name = $sformatf("vec%0d", v);
            for (int i = 0; i < 32; i++) msg_buf[i] = vecs[v].fill;
            pat_buf = vecs[v].pat;
            exp_ctb = vecs[v].ctb;
            exp_cto = vecs[v].cto;
            exp_cts = vecs[v].cts;
            load_dut();
            apply_stimulus(name);
            wait_done(edges);
            check_results(name, edges);
            if (v == 3) begin
                for (int i = 0; i < 32; i++)
                    check_output($sformatf("vec3_msg%0d", i), int'(dut.dm1.core[i]), 0);
                check_output("vec3_pat", int'(dut.dm1.core[32]), 1);
            end
        end

        // Reset while done is high must drop done without a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_done_drop", int'(done), 0);

        for (int r = 0; r < 50; r++) begin
            for (int i = 0; i < 32; i++) msg_buf[i] = 8'($urandom);
            pat_buf = 8'($urandom);
            compute_model();
            load_dut();
            apply_stimulus($sformatf("rand%0d", r));
            wait_done(edges);
            check_results($sformatf("rand%0d", r), edges);
        end

        // Abort a run partway through the scan and restart it.
        for (int i = 0; i < 32; i++) msg_buf[i] = 8'($urandom);
        msg_buf[5] = 8'h1F;
        pat_buf    = 8'h1F;
        compute_model();
        load_dut();
        apply_stimulus("abort");
        repeat (10) @(posedge clk);
        #1;
        check_output("abort_midrun_done", int'(done), 0);
        reset = 1'b1;
        #1;
        check_output("abort_reset_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_done(edges);
        check_results("abort", edges);

        // Non-search program: done after one edge and result bytes untouched.
        dut_np.dm1.core[33] = 8'hEE;
        dut_np.dm1.core[34] = 8'hEE;
        dut_np.dm1.core[35] = 8'hEE;
        @(negedge clk);
        check_output("noop_reset_done", int'(done_np), 0);
        reset_np = 1'b0;
        edges = 0;
        while (!done_np && edges < MAX_EDGES) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_output("noop_latency", edges, 1);
        check_output("noop_core33", int'(dut_np.dm1.core[33]), 8'hEE);
        check_output("noop_core34", int'(dut_np.dm1.core[34]), 8'hEE);
        check_output("noop_core35", int'(dut_np.dm1.core[35]), 8'hEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
